// File: rtl/pwm_demod_pkg.sv
// Shared types and constants for the PWM demodulator.
// The optional glitch filter is enabled by defining PWM_DEMOD_FILTER_EN.
package pwm_demod_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   localparam int DUTY_BITS  = 8;
   localparam int FILTER_LEN = 3;

endpackage

// File: rtl/pwm_demod_div.sv
// Restoring divider computing floor(num * 2^DUTY_BITS / den), one quotient bit per cycle.
// Requires num < den so the quotient fits DUTY_BITS bits.
module pwm_demod_div #(
   parameter int WIDTH     = 16,
   parameter int DUTY_BITS = pwm_demod_pkg::DUTY_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 cancel_i,
   input  logic [WIDTH-1:0]     num_i,
   input  logic [WIDTH-1:0]     den_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [DUTY_BITS-1:0] quot_o
);

   localparam int IW = (DUTY_BITS > 1) ? $clog2(DUTY_BITS) : 1;
   localparam logic [IW-1:0] LAST_ITER = IW'(DUTY_BITS - 1);

   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [IW-1:0]        iter_q, iter_d;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     den_q, den_d;
   logic [DUTY_BITS-1:0] acc_q, acc_d;
   logic [DUTY_BITS-1:0] quot_q, quot_d;

   logic [WIDTH:0]       rem_sh;
   logic                 fits;
   logic [DUTY_BITS-1:0] acc_next;

   // The remainder always stays below den, so its top bit is free for the shift.
   assign rem_sh   = {rem_q[WIDTH-1:0], 1'b0};
   assign fits     = (rem_sh >= {1'b0, den_q});
   assign acc_next = {acc_q[DUTY_BITS-2:0], fits};

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      iter_d = iter_q;
      rem_d  = rem_q;
      den_d  = den_q;
      acc_d  = acc_q;
      quot_d = quot_q;
      if (start_i) begin
         busy_d = 1'b1;
         iter_d = '0;
         rem_d  = {1'b0, num_i};
         den_d  = den_i;
         acc_d  = '0;
      end else if (busy_q) begin
         rem_d  = fits ? (rem_sh - {1'b0, den_q}) : rem_sh;
         acc_d  = acc_next;
         iter_d = iter_q + IW'(1);
         if (iter_q == LAST_ITER) begin
            busy_d = 1'b0;
            if (!cancel_i) begin
               quot_d = acc_next;
               done_d = 1'b1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         iter_q <= '0;
         rem_q  <= '0;
         den_q  <= '0;
         acc_q  <= '0;
         quot_q <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         iter_q <= iter_d;
         rem_q  <= rem_d;
         den_q  <= den_d;
         acc_q  <= acc_d;
         quot_q <= quot_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign quot_o = quot_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: synchronizes pwm_in, measures high time and period, derives an 8-bit duty.
// Define PWM_DEMOD_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module pwm_demod
   import pwm_demod_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pwm_in,
   output logic [WIDTH-1:0]     high_o,
   output logic [WIDTH-1:0]     period_o,
   output logic                 valid_o,
   output logic [DUTY_BITS-1:0] duty_o,
   output logic                 duty_valid_o,
   output logic                 stuck_o,
   output logic                 level_o
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;
   logic                   lvl;
   logic                   lvl_q;
   logic                   rise, fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEMOD_FILTER_EN
   logic [FILTER_LEN-2:0] hist_q;
   logic                  filt_q;
   logic [FILTER_LEN-1:0] win;

   // The window includes the live synchronizer output, so a new level appears FILTER_LEN-1 cycles late.
   assign win = {hist_q, sync_lvl};

   always_comb begin
      lvl = filt_q;
      if (&win)       lvl = 1'b1;
      else if (~|win) lvl = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[FILTER_LEN-3:0], sync_lvl};
         filt_q <= lvl;
      end
   end
`else
   assign lvl = sync_lvl;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lvl_q <= 1'b0;
      else     lvl_q <= lvl;
   end

   assign rise = lvl & ~lvl_q;
   assign fall = ~lvl & lvl_q;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      high_d   = high_q;
      period_d = period_q;
      valid_d  = 1'b0;
      stuck_d  = stuck_q;
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = HIGH;
               cnt_d   = CNT_ONE;
               stuck_d = 1'b0;
            end
         end
         HIGH: begin
            if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               stuck_d = 1'b1;
            end else if (fall) begin
               hi_d    = cnt_q;
               cnt_d   = cnt_q + CNT_ONE;
               state_d = LOW;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         LOW: begin
            if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               stuck_d = 1'b1;
            end else if (rise) begin
               high_d   = hi_q;
               period_d = cnt_q;
               valid_d  = 1'b1;
               cnt_d    = CNT_ONE;
               state_d  = HIGH;
            end else begin
               cnt_d    = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         high_q   <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         high_q   <= high_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         stuck_q  <= stuck_d;
      end
   end

   logic div_busy;
   logic div_cancel;

   // A measurement landing on the cycle the result would appear wins over that result.
   assign div_cancel = valid_d & div_busy;

   pwm_demod_div #(
      .WIDTH     (WIDTH),
      .DUTY_BITS (DUTY_BITS)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start_i  (valid_q),
      .cancel_i (div_cancel),
      .num_i    (high_q),
      .den_i    (period_q),
      .busy_o   (div_busy),
      .done_o   (duty_valid_o),
      .quot_o   (duty_o)
   );

   assign high_o   = high_q;
   assign period_o = period_q;
   assign valid_o  = valid_q;
   assign stuck_o  = stuck_q;
   assign level_o  = lvl;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: a WIDTH=16 instance for measurement/duty and a WIDTH=8 instance for timeout.
module tb_pwm_demod;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16, pwm16, rst8, pwm8;
   logic [15:0] high16, period16;
   logic [7:0]  high8, period8, duty16, duty8;
   logic        valid16, duty_valid16, stuck16, level16;
   logic        valid8, duty_valid8, stuck8, level8;

   pwm_demod #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
      .clk(clk), .rst(rst16), .pwm_in(pwm16),
      .high_o(high16), .period_o(period16), .valid_o(valid16),
      .duty_o(duty16), .duty_valid_o(duty_valid16),
      .stuck_o(stuck16), .level_o(level16)
   );

   pwm_demod #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst(rst8), .pwm_in(pwm8),
      .high_o(high8), .period_o(period8), .valid_o(valid8),
      .duty_o(duty8), .duty_valid_o(duty_valid8),
      .stuck_o(stuck8), .level_o(level8)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int v_cyc[$], v_hi[$], v_per[$], d_cyc[$], d_val[$];
   int lvl_hi_cnt = 0;
   int v8_cnt     = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (valid16 === 1'b1) begin
         v_cyc.push_back(cyc);
         v_hi.push_back(int'(high16));
         v_per.push_back(int'(period16));
      end
      if (duty_valid16 === 1'b1) begin
         d_cyc.push_back(cyc);
         d_val.push_back(int'(duty16));
      end
      if (level16 === 1'b1) lvl_hi_cnt++;
      if (valid8 === 1'b1) v8_cnt++;
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      v_cyc.delete(); v_hi.delete(); v_per.delete();
      d_cyc.delete(); d_val.delete();
      lvl_hi_cnt = 0;
   endtask

   task automatic reset16();
      rst16 = 1'b1;
      pwm16 = 1'b0;
      cycles(3);
      rst16 = 1'b0;
      cycles(2);
      clear_log();
   endtask

   task automatic drive16(input int h, input int l, input int n);
      for (int i = 0; i < n; i++) begin
         pwm16 = 1'b1;
         cycles(h);
         pwm16 = 1'b0;
         cycles(l);
      end
   endtask

   // Checks every logged measurement against one expected high/period pair and spacing.
   task automatic check_valids(input string tag, input int n, input int hi, input int per);
      checks++;
      if (v_cyc.size() !== n) begin
         errors++;
         $display("FAIL %s valid count: got %0d expected %0d", tag, v_cyc.size(), n);
      end
      for (int i = 0; i < v_cyc.size(); i++) begin
         checks++;
         if (v_hi[i] !== hi || v_per[i] !== per) begin
            errors++;
            $display("FAIL %s meas[%0d]: got %0d/%0d expected %0d/%0d", tag, i, v_hi[i], v_per[i], hi, per);
         end
         if (i > 0) begin
            checks++;
            if (v_cyc[i] - v_cyc[i-1] !== per) begin
               errors++;
               $display("FAIL %s spacing[%0d]: got %0d expected %0d", tag, i, v_cyc[i] - v_cyc[i-1], per);
            end
         end
      end
   endtask

   task automatic check_duty_once(input string tag, input int duty);
      checks++;
      if (d_cyc.size() !== 1) begin
         errors++;
         $display("FAIL %s duty_valid count: got %0d expected 1", tag, d_cyc.size());
      end else begin
         checks++;
         if (d_val[0] !== duty) begin
            errors++;
            $display("FAIL %s duty: got %0d expected %0d", tag, d_val[0], duty);
         end
         if (v_cyc.size() > 0) begin
            checks++;
            if (d_cyc[0] - v_cyc[v_cyc.size()-1] !== 9) begin
               errors++;
               $display("FAIL %s duty latency: got %0d expected 9", tag, d_cyc[0] - v_cyc[v_cyc.size()-1]);
            end
         end
      end
      checks++;
      if (int'(duty16) !== duty) begin
         errors++;
         $display("FAIL %s duty_o hold: got %0d expected %0d", tag, duty16, duty);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (high16 !== 16'd0 || period16 !== 16'd0 || duty16 !== 8'd0) begin
         errors++;
         $display("FAIL %s data: got %0d/%0d/%0d expected 0/0/0", tag, high16, period16, duty16);
      end
      checks++;
      if ({valid16, duty_valid16, stuck16, level16} !== 4'b0000) begin
         errors++;
         $display("FAIL %s flags: got %b expected 0000", tag, {valid16, duty_valid16, stuck16, level16});
      end
   endtask

   task automatic test_reset();
      rst16 = 1'b1; pwm16 = 1'b0;
      rst8  = 1'b1; pwm8  = 1'b0;
      cycles(3);
      check_reset_values("reset16");
      checks++;
      if ({high8, period8, duty8} !== 24'd0 || {valid8, duty_valid8, stuck8, level8} !== 4'b0000) begin
         errors++;
         $display("FAIL reset8: got %0d/%0d/%0d flags %b expected zeros", high8, period8, duty8,
                  {valid8, duty_valid8, stuck8, level8});
      end
      rst16 = 1'b0;
      rst8  = 1'b0;
      cycles(2);
   endtask

   task automatic test_h3l5();
      reset16();
      drive16(3, 5, 6);
      pwm16 = 1'b0;
      cycles(30);
      check_valids("h3l5", 5, 3, 8);
      check_duty_once("h3l5", 96);
   endtask

   task automatic test_h1l1();
      reset16();
      drive16(1, 1, 10);
      pwm16 = 1'b0;
      cycles(4);
      check_valids("h1l1", 9, 1, 2);
      checks++;
      if (d_cyc.size() !== 0 || duty16 !== 8'd0) begin
         errors++;
         $display("FAIL h1l1 duty: got %0d pulses duty %0d expected 0 pulses duty 0", d_cyc.size(), duty16);
      end
   endtask

   task automatic test_h255l1();
      reset16();
      drive16(255, 1, 2);
      pwm16 = 1'b0;
      cycles(20);
      check_valids("h255l1", 1, 255, 256);
      check_duty_once("h255l1", 255);
   endtask

   task automatic test_stuck();
      rst8 = 1'b1; pwm8 = 1'b0;
      cycles(3);
      rst8 = 1'b0;
      cycles(5);
      v8_cnt = 0;
      pwm8 = 1'b1;
      cycles(100);
      checks++;
      if (stuck8 !== 1'b0 || level8 !== 1'b1) begin
         errors++;
         $display("FAIL stuck early: got stuck %b level %b expected 0 1", stuck8, level8);
      end
      cycles(200);
      checks++;
      if (stuck8 !== 1'b1 || level8 !== 1'b1) begin
         errors++;
         $display("FAIL stuck timeout: got stuck %b level %b expected 1 1", stuck8, level8);
      end
      pwm8 = 1'b0;
      cycles(10);
      checks++;
      if (stuck8 !== 1'b1) begin
         errors++;
         $display("FAIL stuck hold: got %b expected 1", stuck8);
      end
      pwm8 = 1'b1;
      cycles(6);
      checks++;
      if (stuck8 !== 1'b0) begin
         errors++;
         $display("FAIL stuck clear: got %b expected 0", stuck8);
      end
      checks++;
      if (v8_cnt !== 0 || high8 !== 8'd0 || period8 !== 8'd0) begin
         errors++;
         $display("FAIL stuck outputs: got %0d valids %0d/%0d expected 0 valids 0/0", v8_cnt, high8, period8);
      end
   endtask

   task automatic test_reset_mid();
      reset16();
      drive16(40, 60, 2);
      pwm16 = 1'b1;
      cycles(20);
      checks++;
      if (high16 !== 16'd40 || period16 !== 16'd100 || duty16 !== 8'd102) begin
         errors++;
         $display("FAIL pre-reset: got %0d/%0d duty %0d expected 40/100 duty 102", high16, period16, duty16);
      end
      rst16 = 1'b1;
      cycles(1);
      check_reset_values("mid reset");
      cycles(19);
      pwm16 = 1'b0;
      cycles(10);
      rst16 = 1'b0;
      clear_log();
      cycles(40);
      drive16(40, 60, 1);
      pwm16 = 1'b1;
      cycles(40);
      pwm16 = 1'b0;
      cycles(20);
      check_valids("after reset", 1, 40, 100);
      check_duty_once("after reset", 102);
   endtask

   task automatic test_filter();
      int exp_lvl;
      int exp_valid;
      reset16();
`ifdef PWM_DEMOD_FILTER_EN
      exp_lvl   = 0;
      exp_valid = 0;
`else
      exp_lvl   = 3;
      exp_valid = 1;
`endif
      pwm16 = 1'b1;
      cycles(1);
      pwm16 = 1'b0;
      cycles(9);
      pwm16 = 1'b1;
      cycles(2);
      pwm16 = 1'b0;
      cycles(20);
      checks++;
      if (lvl_hi_cnt !== exp_lvl) begin
         errors++;
         $display("FAIL glitch level cycles: got %0d expected %0d", lvl_hi_cnt, exp_lvl);
      end
      check_valids("glitch", exp_valid, 1, 10);
   endtask

   initial begin
      rst16 = 1'b1; pwm16 = 1'b0;
      rst8  = 1'b1; pwm8  = 1'b0;
      test_reset();
      test_h3l5();
`ifndef PWM_DEMOD_FILTER_EN
      test_h1l1();
      test_h255l1();
`endif
      test_stuck();
      test_reset_mid();
      test_filter();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
